// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths and word type for the ram_512 memory slice
package mem_pkg;

    localparam int DATA_W        = 16;
    localparam int RAM512_ADDR_W = 9;
    localparam int RAM64_ADDR_W  = 6;
    localparam int BANK_SEL_W    = 3;
    localparam int NUM_BANKS     = 1 << BANK_SEL_W;
    localparam int BANK_DEPTH    = 1 << RAM64_ADDR_W;

    typedef logic [DATA_W-1:0] word_t;

    function automatic logic [BANK_SEL_W-1:0] bank_of(input logic [RAM512_ADDR_W-1:0] a);
        return a[RAM512_ADDR_W-1:RAM64_ADDR_W];
    endfunction

endpackage

// File: rtl/ram_512_if.sv
// rtl/ram_512_if.sv - single-port memory bus: address, write data, load, read data
interface ram_512_if;
    import mem_pkg::*;

    word_t                    in;
    word_t                    out;
    logic [RAM512_ADDR_W-1:0] address;
    logic                     load;

    modport master (output in, output address, output load, input out);
    modport slave  (input in, input address, input load, output out);

endinterface

// File: rtl/ram_64.sv
// rtl/ram_64.sv - 64 x 16 bank, combinational read, synchronous write, async clear
module ram_64
    import mem_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    output word_t                   out,
    input  word_t                   in,
    input  logic [RAM64_ADDR_W-1:0] address,
    input  logic                    load
);

    word_t mem [BANK_DEPTH];

    // Whole-array clear keeps out at zero for as long as rst_n is held low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BANK_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (load) begin
            mem[address] <= in;
        end
    end

    assign out = mem[address];

endmodule

// File: rtl/ram_512.sv
// rtl/ram_512.sv - 512 x 16 RAM from eight ram_64 banks; RAM_WRITE_THROUGH_EN bypasses in to out while loading
module ram_512
    import mem_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    ram_512_if.slave bus
);

    logic [BANK_SEL_W-1:0]   bank_sel;
    logic [RAM64_ADDR_W-1:0] word_sel;
    logic [NUM_BANKS-1:0]    bank_load;
    word_t                   bank_out [NUM_BANKS];
    word_t                   stored;

    assign bank_sel = bank_of(bus.address);
    assign word_sel = bus.address[RAM64_ADDR_W-1:0];

    always_comb begin
        bank_load = '0;
        bank_load[bank_sel] = bus.load;
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        ram_64 u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .out     (bank_out[b]),
            .in      (bus.in),
            .address (word_sel),
            .load    (bank_load[b])
        );
    end

    assign stored = bank_out[bank_sel];

`ifdef RAM_WRITE_THROUGH_EN
    // Bypass is gated by rst_n so reset still forces a zero read.
    assign bus.out = (bus.load && rst_n) ? bus.in : stored;
`else
    assign bus.out = stored;
`endif

endmodule

// File: tb/tb_ram_512.sv
// tb/tb_ram_512.sv - directed plus random checks of ram_512 against an array model
module tb_ram_512;
    import mem_pkg::*;

`ifdef RAM_WRITE_THROUGH_EN
    localparam bit WT = 1'b1;
`else
    localparam bit WT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_512_if bus();

    ram_512 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    word_t model [512];
    int    tests  = 0;
    int    fails  = 0;
    bit    chk_en = 1'b0;

    function automatic word_t expect_out();
        if (!rst_n) return '0;
        if (WT && bus.load) return bus.in;
        return model[bus.address];
    endfunction

    always @(posedge clk) begin
        if (rst_n && bus.load) model[bus.address] = bus.in;
    end

    always @(negedge rst_n) begin
        for (int i = 0; i < 512; i++) model[i] = '0;
    end

    // Per-cycle comparison, half a period away from the write edge.
    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if (bus.out !== expect_out()) begin
                fails++;
                $display("FAIL cycle_cmp t=%0t addr=%h load=%b out=%h expected=%h",
                         $time, bus.address, bus.load, bus.out, expect_out());
            end
        end
    end

    task automatic drive(input logic [8:0] a, input word_t d, input logic l);
        @(posedge clk);
        #1;
        bus.address = a;
        bus.in      = d;
        bus.load    = l;
    endtask

    task automatic lit(input string name, input word_t exp);
        #1;
        tests++;
        if (bus.out !== exp) begin
            fails++;
            $display("FAIL %s addr=%h out=%h expected=%h", name, bus.address, bus.out, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) model[i] = '0;
        bus.address = '0;
        bus.in      = '0;
        bus.load    = 1'b0;

        // Reset, released between edges
        drive(9'h000, 16'h0000, 1'b0);
        drive(9'h000, 16'h0000, 1'b0);
        #3 rst_n = 1'b1;
        chk_en = 1'b1;
        lit("rst_read_000", 16'h0000);
        drive(9'h1FF, 16'h0000, 1'b0);
        lit("rst_read_1ff", 16'h0000);

        // Write / readback
        drive(9'h000, 16'hABAB, 1'b1);
        drive(9'h03F, 16'hCDCD, 1'b1);
        drive(9'h000, 16'h1111, 1'b0);
        lit("wr_read_000", 16'hABAB);
        drive(9'h03F, 16'h1111, 1'b0);
        lit("wr_read_03f", 16'hCDCD);

        // Hold with load low
        for (int i = 0; i < 4; i++) drive(9'h000, 16'h1111, 1'b0);
        lit("hold_000", 16'hABAB);

        // Bank boundaries
        drive(9'h03F, 16'h0001, 1'b1);
        drive(9'h040, 16'h0002, 1'b1);
        drive(9'h1FF, 16'h0003, 1'b1);
        drive(9'h03F, 16'h0000, 1'b0); lit("bnd_03f", 16'h0001);
        drive(9'h040, 16'h0000, 1'b0); lit("bnd_040", 16'h0002);
        drive(9'h1FF, 16'h0000, 1'b0); lit("bnd_1ff", 16'h0003);
        drive(9'h03E, 16'h0000, 1'b0); lit("bnd_03e", 16'h0000);
        drive(9'h041, 16'h0000, 1'b0); lit("bnd_041", 16'h0000);
        drive(9'h1FE, 16'h0000, 1'b0); lit("bnd_1fe", 16'h0000);
        drive(9'h000, 16'h0000, 1'b0); lit("bnd_000", 16'hABAB);

        // Read during write
        drive(9'h000, 16'h5555, 1'b1);
        lit("rdw_before", WT ? 16'h5555 : 16'hABAB);
        drive(9'h000, 16'h5555, 1'b0);
        lit("rdw_after", 16'h5555);

        // Reset mid-operation, write attempted while held
        drive(9'h005, 16'h1234, 1'b1);
        drive(9'h100, 16'h4321, 1'b1);
        drive(9'h1FF, 16'h9999, 1'b1);
        drive(9'h1FF, 16'h0000, 1'b0);
        lit("pre_rst_1ff", 16'h9999);
        #1 rst_n = 1'b0;
        lit("async_rst_1ff", 16'h0000);
        drive(9'h007, 16'hBEEF, 1'b1);
        lit("rst_held_wr", 16'h0000);
        drive(9'h007, 16'h0000, 1'b0);
        #2 rst_n = 1'b1;
        lit("rst_wr_ignored", 16'h0000);
        drive(9'h005, 16'h0000, 1'b0); lit("rst_clr_005", 16'h0000);
        drive(9'h100, 16'h0000, 1'b0); lit("rst_clr_100", 16'h0000);

        // Random traffic with occasional mid-cycle reset pulses
        for (int n = 0; n < 3000; n++) begin
            logic [8:0] a;
            if ($urandom_range(1, 0) == 1) a = 9'($urandom_range(15, 0)) | 9'({$urandom_range(7, 0), 6'h3C});
            else a = 9'($urandom);
            drive(a, 16'($urandom), 1'($urandom_range(1, 0)));
            if ($urandom_range(499, 0) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        drive(9'h000, 16'h0000, 1'b0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
